// File: rtl/visaccum_ctrl_if.sv
// Stream bundle between the correlator array, the capture sequencer and visaccum.
// The master side is the sequencer; the slave side is the correlator/visaccum environment.
interface visaccum_ctrl_if #(
    parameter int IBITS = 4
);
    // correlator partial-sum stream into the sequencer
    logic             src_valid_i;
    logic             src_first_i;
    logic [IBITS-1:0] src_rdata_i;
    logic [IBITS-1:0] src_idata_i;
    // gated stream out to visaccum
    logic             acc_frame_o;
    logic             acc_valid_o;
    logic [IBITS-1:0] acc_rdata_o;
    logic [IBITS-1:0] acc_idata_o;
    // block-complete status back from visaccum
    logic             acc_valid_i;
    logic             acc_last_i;

    modport master (
        input  src_valid_i, src_first_i, src_rdata_i, src_idata_i,
        input  acc_valid_i, acc_last_i,
        output acc_frame_o, acc_valid_o, acc_rdata_o, acc_idata_o
    );

    modport slave (
        output src_valid_i, src_first_i, src_rdata_i, src_idata_i,
        output acc_valid_i, acc_last_i,
        input  acc_frame_o, acc_valid_o, acc_rdata_o, acc_idata_o
    );
endinterface

// File: rtl/visaccum_ctrl.sv
// Capture sequencer: gates correlator partial sums into visaccum in whole rounds/blocks.
// Define VISACCUM_CTRL_TIMEOUT_EN to add a watchdog on the DRAIN state.
module visaccum_ctrl #(
    parameter int IBITS   = 4,
    parameter int PSUMS   = 3,
    parameter int COUNT   = 5,
    parameter int NBITS   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [NBITS-1:0] nblocks_i,
    visaccum_ctrl_if.master  bus,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [NBITS-1:0] blocks_o
);
    localparam int PW        = (PSUMS > 1) ? $clog2(PSUMS) : 1;
    localparam int RW        = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int FLUSH_LEN = PSUMS + 4;
    localparam int TMR_MAX   = (FLUSH_LEN > TIMEOUT) ? FLUSH_LEN : TIMEOUT;
    localparam int TW        = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        FLUSH = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [PW-1:0]    pidx_reg, pidx_next;
    logic [RW-1:0]    rnd_reg, rnd_next;
    logic [NBITS-1:0] blk_reg, blk_next;
    logic [NBITS-1:0] nblocks_reg, nblocks_next;
    logic [NBITS-1:0] blocks_reg, blocks_next;
    logic             err_reg, err_next;
    logic             done_reg, done_next;
    logic             frame_reg, frame_next;
    logic             valid_reg, valid_next;
    // one timer serves both the FLUSH countdown and the drain watchdog
    logic [TW-1:0]    tmr_reg, tmr_next;

    logic             blk_event;
    logic             final_part;
    logic             mid_round_gap;
    logic             stray_first;

    assign blk_event     = bus.acc_valid_i && bus.acc_last_i;
    assign final_part    = (nblocks_reg != '0) &&
                           (pidx_reg == PW'(PSUMS - 1)) &&
                           (rnd_reg == RW'(COUNT - 1)) &&
                           (blk_reg == nblocks_reg - 1'b1);
    assign mid_round_gap = !bus.src_valid_i && (pidx_reg != '0);
    assign stray_first   = bus.src_valid_i && bus.src_first_i && (pidx_reg != '0);

    always_comb begin
        state_next   = state_reg;
        pidx_next    = pidx_reg;
        rnd_next     = rnd_reg;
        blk_next     = blk_reg;
        nblocks_next = nblocks_reg;
        blocks_next  = blocks_reg;
        err_next     = err_reg;
        done_next    = 1'b0;
        frame_next   = 1'b0;
        valid_next   = 1'b0;
        tmr_next     = tmr_reg;

        if ((state_reg != IDLE) && blk_event && (blocks_reg != '1)) begin
            blocks_next = blocks_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (start_i && !abort_i) begin
                    state_next   = ARM;
                    nblocks_next = nblocks_i;
                    err_next     = 1'b0;
                    blocks_next  = '0;
                    pidx_next    = '0;
                    rnd_next     = '0;
                    blk_next     = '0;
                end
            end
            ARM: begin
                if (abort_i) begin
                    state_next = FLUSH;
                    tmr_next   = '0;
                end else if (bus.src_valid_i && bus.src_first_i) begin
                    valid_next = 1'b1;
                    frame_next = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                frame_next = 1'b1;
                if (abort_i) begin
                    state_next = FLUSH;
                    tmr_next   = '0;
                    frame_next = 1'b0;
                end else if (mid_round_gap || stray_first) begin
                    err_next   = 1'b1;
                    state_next = FLUSH;
                    tmr_next   = '0;
                    frame_next = 1'b0;
                end else if (bus.src_valid_i) begin
                    valid_next = 1'b1;
                    if (final_part) begin
                        state_next = DRAIN;
                        tmr_next   = '0;
                    end
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_next = FLUSH;
                    tmr_next   = '0;
                end else if (blocks_reg == nblocks_reg) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
`ifdef VISACCUM_CTRL_TIMEOUT_EN
                end else if (bus.acc_last_i) begin
                    tmr_next = '0;
                end else if (tmr_reg == TW'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
`else
                end
                // no watchdog: only the final block, abort or reset leave DRAIN
`endif
            end
            FLUSH: begin
                if (tmr_reg == TW'(FLUSH_LEN - 1)) begin
                    state_next = IDLE;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // position of the partial being forwarded; nblocks=0 lets blk wrap freely
        if (valid_next) begin
            if (pidx_reg == PW'(PSUMS - 1)) begin
                pidx_next = '0;
                if (rnd_reg == RW'(COUNT - 1)) begin
                    rnd_next = '0;
                    blk_next = blk_reg + 1'b1;
                end else begin
                    rnd_next = rnd_reg + 1'b1;
                end
            end else begin
                pidx_next = pidx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            pidx_reg    <= '0;
            rnd_reg     <= '0;
            blk_reg     <= '0;
            nblocks_reg <= '0;
            blocks_reg  <= '0;
            err_reg     <= 1'b0;
            done_reg    <= 1'b0;
            frame_reg   <= 1'b0;
            valid_reg   <= 1'b0;
            tmr_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            pidx_reg    <= pidx_next;
            rnd_reg     <= rnd_next;
            blk_reg     <= blk_next;
            nblocks_reg <= nblocks_next;
            blocks_reg  <= blocks_next;
            err_reg     <= err_next;
            done_reg    <= done_next;
            frame_reg   <= frame_next;
            valid_reg   <= valid_next;
            tmr_reg     <= tmr_next;
        end
    end

    // real and imaginary lanes; data is zeroed whenever nothing is forwarded
    logic [1:0][IBITS-1:0] lane_in;
    assign lane_in = {bus.src_idata_i, bus.src_rdata_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [IBITS-1:0] lane_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    lane_reg <= '0;
                end else begin
                    lane_reg <= valid_next ? lane_in[gi] : '0;
                end
            end
        end
    endgenerate

    assign bus.acc_rdata_o = g_lane[0].lane_reg;
    assign bus.acc_idata_o = g_lane[1].lane_reg;
    assign bus.acc_frame_o = frame_reg;
    assign bus.acc_valid_o = valid_reg;

    assign busy_o   = (state_reg != IDLE);
    assign done_o   = done_reg;
    assign err_o    = err_reg;
    assign blocks_o = blocks_reg;
endmodule

// File: tb/tb_visaccum_ctrl.sv
// Self-checking bench for visaccum_ctrl: directed table rows, hand sequences and
// randomized captures checked against a stream-level reference model.
`timescale 1ns/1ps
module tb_visaccum_ctrl;
    localparam int IBITS     = 4;
    localparam int PSUMS     = 3;
    localparam int COUNT     = 5;
    localparam int NBITS     = 16;
    localparam int TIMEOUT   = 64;
    localparam int BLK       = PSUMS * COUNT;
    localparam int FLUSH_LEN = PSUMS + 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [NBITS-1:0] nblocks_i = '0;
    logic             busy_o, done_o, err_o;
    logic [NBITS-1:0] blocks_o;

    visaccum_ctrl_if #(.IBITS(IBITS)) bus ();

    visaccum_ctrl #(
        .IBITS(IBITS), .PSUMS(PSUMS), .COUNT(COUNT), .NBITS(NBITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .nblocks_i(nblocks_i),
        .bus      (bus),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .blocks_o (blocks_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic             v;
        logic             f;
        logic [IBITS-1:0] r;
        logic [IBITS-1:0] i;
        logic             ab;
    } cyc_t;

    typedef struct {
        int nb; int pre; int gap; int drop_r; int drop_p; int dup_r; int dup_p;
        int abort_part; int nrounds;
        int e_fwd; int e_frame; int e_blocks; int e_err; int e_done;
    } vec_t;

    cyc_t                   plan[$];
    logic [2*IBITS-1:0]     rd_q[$];     // round partials in stream order
    logic [2*IBITS-1:0]     obs_q[$];    // what the DUT forwarded
    logic [2*IBITS-1:0]     m_q[$];      // what the model says it should forward
    int m_frame, m_err, m_done, m_blocks;

    int checks = 0;
    int failures = 0;

    int frame_cnt = 0, done_cnt = 0, flush_cnt = 0, stub_cnt = 0;
    bit stub_en = 1'b1;
    logic [7:0] pipe = '0;

    // observer plus a stand-in for visaccum: a block-complete pulse a few cycles
    // after every BLK-th forwarded partial
    always @(negedge clock) begin
        pipe = {pipe[6:0], 1'b0};
        if (bus.acc_valid_o) begin
            obs_q.push_back({bus.acc_rdata_o, bus.acc_idata_o});
            stub_cnt++;
            if (stub_en && (stub_cnt % BLK == 0)) pipe[0] = 1'b1;
        end
        if (bus.acc_frame_o) frame_cnt++;
        if (done_o) done_cnt++;
        if (err_o && busy_o) flush_cnt++;
        bus.acc_valid_i = pipe[2];
        bus.acc_last_i  = pipe[2];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        frame_cnt = 0; done_cnt = 0; flush_cnt = 0; stub_cnt = 0;
        pipe = '0; stub_en = 1'b1;
    endtask

    task automatic build_plan(input int pre, input int nrounds, input int gap_lo, input int gap_hi,
                              input int drop_r, input int drop_p, input int dup_r, input int dup_p,
                              input int abort_part);
        cyc_t c;
        int part;
        plan.delete();
        rd_q.delete();
        c = '0;
        plan.push_back(c);                       // start cycle
        for (int p = 0; p < pre; p++) begin      // tail of a round already in flight
            c = '0; c.v = 1'b1;
            c.r = IBITS'($urandom); c.i = IBITS'($urandom);
            plan.push_back(c);
        end
        part = 0;
        for (int r = 0; r < nrounds; r++) begin
            if (r > 0) begin
                int n;
                n = $urandom_range(gap_hi, gap_lo);
                for (int g = 0; g < n; g++) plan.push_back('0);
            end
            for (int p = 0; p < PSUMS; p++) begin
                if (r == drop_r && p == drop_p) plan.push_back('0);
                c    = '0;
                c.v  = 1'b1;
                c.f  = (p == 0) || (r == dup_r && p == dup_p);
                c.r  = IBITS'($urandom);
                c.i  = IBITS'($urandom);
                c.ab = (part == abort_part);
                plan.push_back(c);
                rd_q.push_back({c.r, c.i});
                part++;
            end
        end
        plan.push_back('0);
        plan.push_back('0);
    endtask

    task automatic drive_plan(input int ncyc, input int nb);
        nblocks_i = NBITS'(nb);
        for (int k = 0; k < plan.size() && k < ncyc; k++) begin
            start_i         = (k == 0);
            abort_i         = plan[k].ab;
            bus.src_valid_i = plan[k].v;
            bus.src_first_i = plan[k].f;
            bus.src_rdata_i = plan[k].r;
            bus.src_idata_i = plan[k].i;
            tick();
        end
        start_i = 1'b0; abort_i = 1'b0;
        bus.src_valid_i = 1'b0; bus.src_first_i = 1'b0;
        bus.src_rdata_i = '0;   bus.src_idata_i = '0;
    endtask

    task automatic wait_idle(input int limit);
        for (int n = 0; n < limit && busy_o; n++) tick();
        repeat (3) tick();
    endtask

    // Stream-level reference: walk the offered stream after the start cycle,
    // apply the round/block rules with plain counting.
    task automatic model_run(input int nb);
        int acc, first_k, end_k;
        acc = 0; first_k = -1; end_k = -1;
        m_err = 0; m_done = 0;
        m_q.delete();
        for (int k = 1; k < plan.size(); k++) begin
            if (plan[k].ab) begin end_k = k; break; end
            if (first_k < 0) begin
                if (plan[k].v && plan[k].f) begin
                    first_k = k;
                    m_q.push_back({plan[k].r, plan[k].i});
                    acc = 1;
                end
                continue;
            end
            if ((acc % PSUMS) != 0 && (!plan[k].v || plan[k].f)) begin
                m_err = 1; end_k = k; break;
            end
            if (plan[k].v) begin
                m_q.push_back({plan[k].r, plan[k].i});
                acc++;
            end
            if (nb != 0 && acc == nb * BLK) begin
                m_done = 1; end_k = k + 1; break;
            end
        end
        m_frame  = (first_k < 0 || end_k < 0) ? 0 : end_k - first_k;
        m_blocks = acc / BLK;
    endtask

    function automatic int data_mism(input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            if (k >= obs_q.size()) bad++;
            else if (obs_q[k] !== m_q[k]) bad++;
        end
        return bad;
    endfunction

    vec_t vecs[7];

    initial begin
        bus.src_valid_i = 1'b0; bus.src_first_i = 1'b0;
        bus.src_rdata_i = '0;   bus.src_idata_i = '0;

        // rows: nb pre gap drop_r drop_p dup_r dup_p abort nrounds | fwd frame blocks err done
        vecs[0] = '{2, 0, 0, -1, -1, -1, -1, -1, 10,  30, 30, 2, 0, 1};
        vecs[1] = '{1, 2, 0, -1, -1, -1, -1, -1,  5,  15, 15, 1, 0, 1};
        vecs[2] = '{2, 0, 0,  3,  1, -1, -1, -1, 10,  10, 10, 0, 1, 0};
        vecs[3] = '{0, 0, 0, -1, -1, -1, -1, 61, 25,  61, 61, 4, 0, 0};
        vecs[4] = '{3, 1, 1, -1, -1, -1, -1, -1, 15,  45, 59, 3, 0, 1};
        vecs[5] = '{1, 0, 0, -1, -1,  2,  1, -1,  5,   7,  7, 0, 1, 0};
        vecs[6] = '{1, 0, 2, -1, -1, -1, -1,  4,  5,   4,  6, 0, 0, 0};

        repeat (3) tick();
        chk("rst_busy",   int'(busy_o),          0);
        chk("rst_done",   int'(done_o),          0);
        chk("rst_err",    int'(err_o),           0);
        chk("rst_blocks", int'(blocks_o),        0);
        chk("rst_frame",  int'(bus.acc_frame_o), 0);
        chk("rst_valid",  int'(bus.acc_valid_o), 0);
        reset = 1'b0;
        tick();
        $display("txn reset_state checked");

        // reset in the middle of a capture
        build_plan(0, 5, 0, 0, -1, -1, -1, -1, -1);
        clear_obs();
        drive_plan(8, 1);
        chk("midrun_busy", int'(busy_o), 1);
        reset = 1'b1;
        tick();
        chk("midrst_busy",  int'(busy_o),          0);
        chk("midrst_valid", int'(bus.acc_valid_o), 0);
        chk("midrst_frame", int'(bus.acc_frame_o), 0);
        chk("midrst_data",  int'(bus.acc_rdata_o) + int'(bus.acc_idata_o), 0);
        chk("midrst_done",  int'(done_o),          0);
        chk("midrst_blocks",int'(blocks_o),        0);
        reset = 1'b0;
        tick();
        $display("txn reset_mid_run busy=%0d", busy_o);

        // start and abort together in IDLE: stays idle
        start_i = 1'b1; abort_i = 1'b1; nblocks_i = 16'd1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        tick();
        chk("start_abort_idle", int'(busy_o), 0);
        $display("txn start_with_abort busy=%0d", busy_o);

        // directed table
        for (int n = 0; n < 7; n++) begin
            build_plan(vecs[n].pre, vecs[n].nrounds, vecs[n].gap, vecs[n].gap,
                       vecs[n].drop_r, vecs[n].drop_p, vecs[n].dup_r, vecs[n].dup_p,
                       vecs[n].abort_part);
            m_q.delete();
            for (int k = 0; k < vecs[n].e_fwd; k++) m_q.push_back(rd_q[k]);
            clear_obs();
            drive_plan(plan.size(), vecs[n].nb);
            wait_idle(500);
            chk($sformatf("vec%0d_idle",   n), int'(busy_o),   0);
            chk($sformatf("vec%0d_fwd",    n), obs_q.size(),   vecs[n].e_fwd);
            chk($sformatf("vec%0d_data",   n), data_mism(vecs[n].e_fwd), 0);
            chk($sformatf("vec%0d_frame",  n), frame_cnt,      vecs[n].e_frame);
            chk($sformatf("vec%0d_blocks", n), int'(blocks_o), vecs[n].e_blocks);
            chk($sformatf("vec%0d_err",    n), int'(err_o),    vecs[n].e_err);
            chk($sformatf("vec%0d_done",   n), done_cnt,       vecs[n].e_done);
            chk($sformatf("vec%0d_flush",  n), flush_cnt,      vecs[n].e_err ? FLUSH_LEN : 0);
            $display("txn vec%0d nb=%0d fwd=%0d frame=%0d blocks=%0d err=%0d done=%0d",
                     n, vecs[n].nb, obs_q.size(), frame_cnt, blocks_o, err_o, done_cnt);
        end

        // visaccum never reports the last block: DRAIN behaviour
        build_plan(0, 5, 0, 0, -1, -1, -1, -1, -1);
        clear_obs();
        stub_en = 1'b0;
        drive_plan(plan.size(), 1);
`ifdef VISACCUM_CTRL_TIMEOUT_EN
        wait_idle(400);
        chk("wdog_idle", int'(busy_o), 0);
        chk("wdog_err",  int'(err_o),  1);
        chk("wdog_done", done_cnt,     0);
`else
        repeat (100) tick();
        chk("drain_hold", int'(busy_o), 1);
        chk("drain_done", done_cnt,     0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        wait_idle(100);
        chk("drain_abort_idle", int'(busy_o), 0);
        chk("drain_abort_err",  int'(err_o),  0);
`endif
        $display("txn drain_stall busy=%0d err=%0d done=%0d", busy_o, err_o, done_cnt);

        // randomized captures against the reference model
        for (int t = 0; t < 24; t++) begin
            int kind, nb, pre, gap, nrounds, dr, dp, ur, up, ab;
            kind = $urandom_range(3, 0);
            nb   = $urandom_range(3, 1);
            pre  = $urandom_range(3, 0);
            gap  = $urandom_range(2, 0);
            dr = -1; dp = -1; ur = -1; up = -1; ab = -1;
            nrounds = nb * COUNT + 1;
            if (kind == 1) begin
                dr = $urandom_range(nb * COUNT - 1, 0);
                dp = $urandom_range(PSUMS - 1, 1);
            end else if (kind == 2) begin
                ur = $urandom_range(nb * COUNT - 1, 0);
                up = $urandom_range(PSUMS - 1, 1);
            end else if (kind == 3) begin
                nb = 0;
                nrounds = 12;
                ab = $urandom_range(35, 1);
            end
            build_plan(pre, nrounds, 0, gap, dr, dp, ur, up, ab);
            model_run(nb);
            clear_obs();
            drive_plan(plan.size(), nb);
            wait_idle(500);
            chk("rnd_idle",   int'(busy_o),   0);
            chk("rnd_fwd",    obs_q.size(),   m_q.size());
            chk("rnd_data",   data_mism(m_q.size()), 0);
            chk("rnd_frame",  frame_cnt,      m_frame);
            chk("rnd_blocks", int'(blocks_o), m_blocks);
            chk("rnd_err",    int'(err_o),    m_err);
            chk("rnd_done",   done_cnt,       m_done);
            $display("txn rnd%0d kind=%0d nb=%0d fwd=%0d frame=%0d blocks=%0d err=%0d done=%0d",
                     t, kind, nb, obs_q.size(), frame_cnt, blocks_o, err_o, done_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
